// File: rtl/sd_pic_pkg.sv
// Shared types and constants for the SD picture sequence loader.
// Contents: picture table entry type, default picture table, header/sector
// sizing defaults, loader FSM state and repack phase encodings.
package sd_pic_pkg;

    localparam int unsigned PIC_NUM_DEF     = 7;
    localparam int unsigned HDR_WORDS_DEF   = 27;   // 54-byte BMP header
    localparam int unsigned SEC_WORDS_DEF   = 256;  // 512-byte sector
    localparam int unsigned SWITCH_HOLD_DEF = 16;

    // One picture: first SD sector, number of sectors, SDRAM word base.
    typedef struct packed {
        logic [31:0] start_sec;
        logic [15:0] sec_cnt;
        logic [23:0] base;
    } pic_entry_t;

    // Pictures in load order. Sector placement and counts follow the card
    // image layout; bases follow the SDRAM frame map.
    localparam pic_entry_t [0:PIC_NUM_DEF-1] PIC_TABLE = '{
        '{start_sec: 32'd8192,  sec_cnt: 16'd2251, base: 24'd0},        // BG
        '{start_sec: 32'd10496, sec_cnt: 16'd2251, base: 24'd786432},   // START
        '{start_sec: 32'd12800, sec_cnt: 16'd2251, base: 24'd1572864},  // GAMEOVER
        '{start_sec: 32'd15104, sec_cnt: 16'd235,  base: 24'd2512896},  // PIPE
        '{start_sec: 32'd15360, sec_cnt: 16'd11,   base: 24'd2552896},  // BIRD0
        '{start_sec: 32'd15376, sec_cnt: 16'd11,   base: 24'd2554646},  // BIRD1
        '{start_sec: 32'd15392, sec_cnt: 16'd11,   base: 24'd2556396}   // BIRD2
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SWITCH,
        ST_HOLD,
        ST_REQ,
        ST_WAIT_HI,
        ST_WAIT_LO,
        ST_NEXT,
        ST_DONE
    } load_state_t;

    typedef enum logic [1:0] {
        PH_0,
        PH_1,
        PH_2
    } pack_phase_t;

endpackage

// File: rtl/sd_pic_seq_loader_packer.sv
// bgr888_to_rgb565_packer: drops the per-picture header words and repacks
// the BMP byte stream (B G R B G R, first byte in [15:8]) into RGB565.
// Ports:
//   clk, rst        clock, async active-high reset
//   clear           restart header skip and repack phase (start of picture)
//   word_vld        word_data is an accepted stream word
//   word_data       two stream bytes, earlier byte in [15:8]
//   pix_vld         registered pixel strobe, 1 clk after the completing word
//   pix_data        registered RGB565 pixel
module bgr888_to_rgb565_packer
    import sd_pic_pkg::*;
#(
    parameter int unsigned HDR_WORDS = HDR_WORDS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        word_vld,
    input  logic [15:0] word_data,
    output logic        pix_vld,
    output logic [15:0] pix_data
);

    localparam int unsigned HDR_W = (HDR_WORDS > 0) ? $clog2(HDR_WORDS + 1) : 1;

    logic [HDR_W-1:0] hdr_left;
    pack_phase_t      phase;
    logic [4:0]       hold_b5;   // B0[7:3] in phase 1, B1[7:3] in phase 2
    logic [5:0]       hold_g6;   // G0[7:2]

    // Low bits of G/R/B never reach RGB565.
    logic unused_bits;
    assign unused_bits = ^{word_data[9:8], word_data[1:0]};

    // Header skip counter (carries across sectors) and 3-word / 2-pixel repack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr_left <= HDR_W'(HDR_WORDS);
            phase    <= PH_0;
            hold_b5  <= '0;
            hold_g6  <= '0;
            pix_vld  <= 1'b0;
            pix_data <= '0;
        end else begin
            pix_vld <= 1'b0;
            if (clear) begin
                hdr_left <= HDR_W'(HDR_WORDS);
                phase    <= PH_0;
                hold_b5  <= '0;
                hold_g6  <= '0;
            end else if (word_vld) begin
                if (hdr_left != '0) begin
                    hdr_left <= hdr_left - HDR_W'(1);
                end else begin
                    case (phase)
                        PH_0: begin
                            // {B0, G0}
                            hold_b5 <= word_data[15:11];
                            hold_g6 <= word_data[7:2];
                            phase   <= PH_1;
                        end
                        PH_1: begin
                            // {R0, B1}: pixel0 complete, keep B1
                            pix_vld  <= 1'b1;
                            pix_data <= {word_data[15:11], hold_g6, hold_b5};
                            hold_b5  <= word_data[7:3];
                            phase    <= PH_2;
                        end
                        PH_2: begin
                            // {G1, R1}: pixel1 complete
                            pix_vld  <= 1'b1;
                            pix_data <= {word_data[7:3], word_data[15:10], hold_b5};
                            phase    <= PH_0;
                        end
                        default: phase <= PH_0;
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/sd_pic_seq_loader.sv
// sd_pic_seq_loader: walks the picture table, issues one SD sector read at a
// time and streams the repacked RGB565 pixels toward the SDRAM write port.
// Ports:
//   clk, rst         loader clock, async active-high reset
//   rd_busy          SD read in progress
//   sd_rd_val_en     SD read word valid
//   sd_rd_val_data   SD read word, first byte in [15:8]
//   rd_start_en      one-cycle sector read request
//   rd_sec_addr      sector address, held until the next request
//   sdram_wr_en      RGB565 word valid
//   sdram_wr_data    RGB565 pixel
//   sdram_base_addr  SDRAM base of the picture being loaded
//   pic_switch       one-cycle pulse at the start of each picture
//   pic_load_done    level, all pictures loaded
module sd_pic_seq_loader
    import sd_pic_pkg::*;
#(
    parameter int unsigned PIC_NUM     = PIC_NUM_DEF,
    parameter int unsigned HDR_WORDS   = HDR_WORDS_DEF,
    parameter int unsigned SEC_WORDS   = SEC_WORDS_DEF,
    parameter int unsigned SWITCH_HOLD = SWITCH_HOLD_DEF,
    parameter pic_entry_t [0:PIC_NUM-1] PIC_TAB = PIC_TABLE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_busy,
    input  logic        sd_rd_val_en,
    input  logic [15:0] sd_rd_val_data,
    output logic        rd_start_en,
    output logic [31:0] rd_sec_addr,
    output logic        sdram_wr_en,
    output logic [15:0] sdram_wr_data,
    output logic [23:0] sdram_base_addr,
    output logic        pic_switch,
    output logic        pic_load_done
);

    localparam int unsigned IDX_W     = (PIC_NUM > 1) ? $clog2(PIC_NUM) : 1;
    localparam int unsigned HOLD_W    = (SWITCH_HOLD > 1) ? $clog2(SWITCH_HOLD) : 1;
    localparam int unsigned SWC_W     = $clog2(SEC_WORDS + 1);
    // HOLD plus the REQ cycle make pic_switch -> rd_start_en exactly
    // SWITCH_HOLD cycles when the card is idle.
    localparam int unsigned HOLD_LAST = (SWITCH_HOLD > 1) ? SWITCH_HOLD - 2 : 0;

    load_state_t       state;
    logic [IDX_W-1:0]  pic_idx;
    logic [15:0]       sec_idx;
    logic [HOLD_W-1:0] hold_cnt;
    logic [SWC_W-1:0]  sec_words;
    pic_entry_t        cur;
    logic              word_acc;
    logic              pack_clr;

    assign cur = PIC_TAB[pic_idx];

    // Words count only while a sector read is outstanding, at most one
    // sector's worth per request.
    assign word_acc = sd_rd_val_en
                    && (state == ST_WAIT_HI || state == ST_WAIT_LO)
                    && (sec_words < SWC_W'(SEC_WORDS));
    assign pack_clr = (state == ST_SWITCH);

    // Picture / sector sequencing FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            pic_idx         <= '0;
            sec_idx         <= '0;
            hold_cnt        <= '0;
            sec_words       <= '0;
            rd_start_en     <= 1'b0;
            rd_sec_addr     <= '0;
            sdram_base_addr <= PIC_TAB[0].base;
            pic_switch      <= 1'b0;
            pic_load_done   <= 1'b0;
        end else begin
            rd_start_en <= 1'b0;
            pic_switch  <= 1'b0;
            if (word_acc) begin
                sec_words <= sec_words + SWC_W'(1);
            end
            case (state)
                ST_IDLE: state <= ST_SWITCH;
                ST_SWITCH: begin
                    sdram_base_addr <= cur.base;
                    sec_idx         <= '0;
                    hold_cnt        <= '0;
                    pic_switch      <= 1'b1;
                    // Empty entries still announce themselves, then move on.
                    state <= (cur.sec_cnt == '0) ? ST_NEXT : ST_HOLD;
                end
                ST_HOLD: begin
                    if (hold_cnt == HOLD_W'(HOLD_LAST)) begin
                        state <= ST_REQ;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                ST_REQ: begin
                    if (!rd_busy) begin
                        rd_start_en <= 1'b1;
                        rd_sec_addr <= cur.start_sec + 32'(sec_idx);
                        sec_words   <= '0;
                        state       <= ST_WAIT_HI;
                    end
                end
                ST_WAIT_HI: begin
                    if (rd_busy) begin
                        state <= ST_WAIT_LO;
                    end
                end
                ST_WAIT_LO: begin
                    if (!rd_busy) begin
                        sec_idx <= sec_idx + 16'(1);
                        state   <= (sec_idx + 16'(1) == cur.sec_cnt) ? ST_NEXT : ST_REQ;
                    end
                end
                ST_NEXT: begin
                    if (pic_idx == IDX_W'(PIC_NUM - 1)) begin
                        pic_load_done <= 1'b1;
                        state         <= ST_DONE;
                    end else begin
                        pic_idx <= pic_idx + IDX_W'(1);
                        state   <= ST_SWITCH;
                    end
                end
                ST_DONE: state <= ST_DONE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    bgr888_to_rgb565_packer #(
        .HDR_WORDS (HDR_WORDS)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (pack_clr),
        .word_vld  (word_acc),
        .word_data (sd_rd_val_data),
        .pix_vld   (sdram_wr_en),
        .pix_data  (sdram_wr_data)
    );

endmodule

// File: tb/tb_sd_pic_seq_loader.sv
// Directed bench: instance A (two entries, second empty, 27-word header)
// covers sequencing, pixel repack, busy stall and mid-load reset; instance B
// (300-word header) covers a header spanning two sectors.
module tb_sd_pic_seq_loader;
    import sd_pic_pkg::*;

    localparam pic_entry_t [0:1] TAB_A = '{
        '{start_sec: 32'd100, sec_cnt: 16'd2, base: 24'd0},
        '{start_sec: 32'd200, sec_cnt: 16'd0, base: 24'h001234}
    };
    localparam pic_entry_t [0:0] TAB_B = '{
        '{start_sec: 32'd500, sec_cnt: 16'd3, base: 24'd0}
    };

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic        rst_a, busy_a, val_a;
    logic [15:0] data_a;
    logic        rd_start_a, wr_a, sw_a, done_a;
    logic [31:0] rd_addr_a;
    logic [15:0] wdata_a;
    logic [23:0] base_a;

    logic        rst_b, busy_b, val_b;
    logic [15:0] data_b;
    logic        rd_start_b, wr_b, sw_b, done_b;
    logic [31:0] rd_addr_b;
    logic [15:0] wdata_b;
    logic [23:0] base_b;

    sd_pic_seq_loader #(
        .PIC_NUM(2), .HDR_WORDS(27), .SEC_WORDS(256), .SWITCH_HOLD(4), .PIC_TAB(TAB_A)
    ) dut_a (
        .clk(clk), .rst(rst_a), .rd_busy(busy_a), .sd_rd_val_en(val_a),
        .sd_rd_val_data(data_a), .rd_start_en(rd_start_a), .rd_sec_addr(rd_addr_a),
        .sdram_wr_en(wr_a), .sdram_wr_data(wdata_a), .sdram_base_addr(base_a),
        .pic_switch(sw_a), .pic_load_done(done_a)
    );

    sd_pic_seq_loader #(
        .PIC_NUM(1), .HDR_WORDS(300), .SEC_WORDS(256), .SWITCH_HOLD(4), .PIC_TAB(TAB_B)
    ) dut_b (
        .clk(clk), .rst(rst_b), .rd_busy(busy_b), .sd_rd_val_en(val_b),
        .sd_rd_val_data(data_b), .rd_start_en(rd_start_b), .rd_sec_addr(rd_addr_b),
        .sdram_wr_en(wr_b), .sdram_wr_data(wdata_b), .sdram_base_addr(base_b),
        .pic_switch(sw_b), .pic_load_done(done_b)
    );

    int checks = 0;
    int errors = 0;
    int wr_cnt_a = 0, st_cnt_a = 0, sw_cnt_a = 0, wr_cnt_b = 0;

    // Pulse counters sampled on the falling edge.
    always @(negedge clk) begin
        if (wr_a)       wr_cnt_a <= wr_cnt_a + 1;
        if (rd_start_a) st_cnt_a <= st_cnt_a + 1;
        if (sw_a)       sw_cnt_a <= sw_cnt_a + 1;
        if (wr_b)       wr_cnt_b <= wr_cnt_b + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one word for one edge; returns 1 after that edge.
    task automatic send_a(input logic [15:0] w);
        val_a = 1'b1; data_a = w;
        @(posedge clk); #1;
        val_a = 1'b0;
    endtask

    task automatic send_b(input logic [15:0] w);
        val_b = 1'b1; data_b = w;
        @(posedge clk); #1;
        val_b = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Release A from reset and check switch pulse and first request timing.
    task automatic startup_a();
        rst_a = 1'b0;
        step(); check("a_idle_no_switch", 32'(sw_a), 0);
        step(); check("a_switch_pulse", 32'(sw_a), 1);
                check("a_base_entry0", 32'(base_a), 0);
        step(); check("a_switch_one_cycle", 32'(sw_a), 0);
        step(); step();
        check("a_no_early_start", 32'(rd_start_a), 0);
        step(); check("a_start_sec0", 32'(rd_start_a), 1);
                check("a_addr_sec0", rd_addr_a, 100);
    endtask

    task automatic check_all_zero_a(input string tag);
        check({tag, "_rd_start"}, 32'(rd_start_a), 0);
        check({tag, "_rd_addr"},  rd_addr_a, 0);
        check({tag, "_wr_en"},    32'(wr_a), 0);
        check({tag, "_wr_data"},  32'(wdata_a), 0);
        check({tag, "_base"},     32'(base_a), 0);
        check({tag, "_switch"},   32'(sw_a), 0);
        check({tag, "_done"},     32'(done_a), 0);
    endtask

    initial begin
        int n;
        int st0;
        rst_a = 1'b1; busy_a = 1'b0; val_a = 1'b0; data_a = '0;
        rst_b = 1'b1; busy_b = 1'b0; val_b = 1'b0; data_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero_a("a_reset");

        // ---- Run 1: full load of table A ----
        startup_a();
        busy_a = 1'b1; step();
        for (int i = 0; i < 27; i++) send_a(16'(i * 257));
        send_a(16'h1122);
        check("a_hdr_no_wr", 32'(wr_cnt_a), 0);
        check("a_phase0_no_wr", 32'(wr_a), 0);
        send_a(16'h3344);
        check("a_pix0_en", 32'(wr_a), 1);
        check("a_pix0_data", 32'(wdata_a), 32'h3102);
        send_a(16'h5566);
        check("a_pix1_en", 32'(wr_a), 1);
        check("a_pix1_data", 32'(wdata_a), 32'h62A8);
        step();
        check("a_wr_drops", 32'(wr_a), 0);
        check("a_wr_count", 32'(wr_cnt_a), 2);

        // Card busy again as soon as REQ is entered: request must wait.
        busy_a = 1'b0; step();
        busy_a = 1'b1; st0 = st_cnt_a;
        repeat (50) @(posedge clk);
        #1;
        check("a_busy_stall_level", 32'(rd_start_a), 0);
        check("a_busy_stall_count", 32'(st_cnt_a - st0), 0);
        busy_a = 1'b0; step();
        check("a_start_sec1", 32'(rd_start_a), 1);
        check("a_addr_sec1", rd_addr_a, 101);
        busy_a = 1'b1; step();
        busy_a = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("a_two_switches", 32'(sw_cnt_a), 2);
        check("a_base_entry1", 32'(base_a), 32'h1234);
        check("a_no_start_entry1", 32'(st_cnt_a), 2);
        check("a_done", 32'(done_a), 1);
        repeat (20) @(posedge clk);
        #1;
        check("a_done_held", 32'(done_a), 1);
        check("a_no_start_after_done", 32'(st_cnt_a), 2);

        // ---- Run 2: reset during WAIT_LO of sector 1 ----
        rst_a = 1'b1; step();
        check("a_rst_clears_done", 32'(done_a), 0);
        startup_a();
        busy_a = 1'b1; step();
        busy_a = 1'b0; step();
        step();
        check("a2_start_sec1", 32'(rd_start_a), 1);
        check("a2_addr_sec1", rd_addr_a, 101);
        busy_a = 1'b1; step();
        for (int i = 0; i < 27; i++) send_a(16'hA5A5);
        send_a(16'h1122);
        send_a(16'h3344);
        check("a2_pix_before_rst", 32'(wdata_a), 32'h3102);
        rst_a = 1'b1; busy_a = 1'b0;
        #1;
        check_all_zero_a("a2_async_rst");
        step();
        startup_a();

        // ---- Instance B: 300-word header spans into sector 2 ----
        rst_b = 1'b0;
        n = 0;
        while (rd_start_b !== 1'b1 && n < 20) begin step(); n++; end
        check("b_start_seen", 32'(rd_start_b), 1);
        check("b_addr_sec0", rd_addr_b, 500);
        busy_b = 1'b1; step();
        for (int i = 0; i < 256; i++) send_b(16'(i));
        busy_b = 1'b0; step();
        step();
        check("b_start_sec1", 32'(rd_start_b), 1);
        check("b_addr_sec1", rd_addr_b, 501);
        busy_b = 1'b1; step();
        for (int i = 0; i < 44; i++) send_b(16'hFFFF);
        check("b_hdr_span_no_wr", 32'(wr_cnt_b), 0);
        send_b(16'h1122);
        check("b_word44_no_wr", 32'(wr_b), 0);
        send_b(16'h3344);
        check("b_pix0_en", 32'(wr_b), 1);
        check("b_pix0_data", 32'(wdata_b), 32'h3102);
        send_b(16'h5566);
        check("b_pix1_data", 32'(wdata_b), 32'h62A8);
        check("b_wr_count", 32'(wr_cnt_b), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
